// File: rtl/ar_br_cr_pkg.sv
// Shared types and constants for the AR/BR/CR job issuer and its operand FIFO.
package ar_br_cr_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESULT
  } state_e;

  // Timer counts 0..TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  function automatic int timer_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/ar_br_cr_op_fifo.sv
// Operand-pair FIFO: DEPTH entries (power of two), pointers wrap naturally.
module ar_br_cr_op_fifo
  import ar_br_cr_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ar_br_cr_job_issuer.sv
// Issues buffered AR/BR operand pairs to the datapath one job at a time and returns CR.
// Optional macro ISSUER_STATS_EN adds saturating jobs_done / jobs_aborted counters.
module ar_br_cr_job_issuer
  import ar_br_cr_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              start,
  output logic [DATA_W-1:0] ar_data,
  output logic [DATA_W-1:0] br_data,
  input  logic              busy,
  input  logic [DATA_W-1:0] cr_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              timeout_err
`ifdef ISSUER_STATS_EN
  ,
  output logic [15:0]       jobs_done,
  output logic [15:0]       jobs_aborted
`endif
);

  localparam int TW = timer_w(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   ar_q, ar_d, br_q, br_d, res_q, res_d;
  logic                to_q, to_d;
  logic                pop, full, empty, expired;
  logic [2*DATA_W-1:0] head;

  ar_br_cr_op_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (op_valid && op_ready),
    .pop_i   (pop),
    .din_i   ({op_a, op_b}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign op_ready    = !full;
  assign start       = (state_q == ISSUE);
  assign res_valid   = (state_q == RESULT);
  assign ar_data     = ar_q;
  assign br_data     = br_q;
  assign res_data    = res_q;
  assign timeout_err = to_q;
  assign expired     = (timer_q == TIMER_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ar_d    = ar_q;
    br_d    = br_q;
    res_d   = res_q;
    to_d    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          ar_d    = head[2*DATA_W-1 -: DATA_W];
          br_d    = head[DATA_W-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK, WAIT_DONE: begin
        // Ack needs busy seen high on an edge; completion needs it seen low after that.
        if ((state_q == WAIT_ACK) && busy) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if ((state_q == WAIT_DONE) && !busy) begin
          res_d   = cr_data;
          pop     = 1'b1;
          state_d = RESULT;
        end else if (expired) begin
          pop     = 1'b1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      ar_q    <= '0;
      br_q    <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

`ifdef ISSUER_STATS_EN
  logic [15:0] done_q, aborted_q;
  logic        capture;

  assign capture      = (state_q == WAIT_DONE) && !busy;
  assign jobs_done    = done_q;
  assign jobs_aborted = aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= '0;
      aborted_q <= '0;
    end else begin
      if (capture && (done_q != 16'hFFFF))  done_q    <= done_q + 16'd1;
      if (to_d && (aborted_q != 16'hFFFF))  aborted_q <= aborted_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ar_br_cr_job_issuer.sv
// Bench for ar_br_cr_job_issuer: a queue model of accepted/issued/retired jobs checked
// every cycle, a small datapath model, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ar_br_cr_job_issuer;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          start;
  logic [DW-1:0] ar_data, br_data;
  logic          busy, dp_busy, stall;
  logic [DW-1:0] cr_data;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          timeout_err;
`ifdef ISSUER_STATS_EN
  logic [15:0]   jobs_done, jobs_aborted;
`endif

  assign busy = dp_busy | stall;
  always #5 clk = ~clk;

  ar_br_cr_job_issuer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .start       (start),
    .ar_data     (ar_data),
    .br_data     (br_data),
    .busy        (busy),
    .cr_data     (cr_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .timeout_err (timeout_err)
`ifdef ISSUER_STATS_EN
    ,
    .jobs_done    (jobs_done),
    .jobs_aborted (jobs_aborted)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  // Bench datapath: CR = AR - BR + 10, busy rises 2 cycles after start and lasts 5 cycles.
  function automatic logic [DW-1:0] dp_fn(input pair_t p);
    return p.a - p.b + 16'sd10;
  endfunction

  int    dp_skip = 0;
  pair_t dp_p;

  initial begin
    dp_busy = 1'b0;
    cr_data = '0;
    forever begin
      @(posedge clk); #1;
      if (start && !reset) begin
        if (dp_skip > 0) begin
          dp_skip--;
        end else begin
          dp_p = '{ar_data, br_data};
          repeat (2) begin @(posedge clk); #1; end
          dp_busy = 1'b1;
          cr_data = dp_fn(dp_p);
          repeat (5) begin @(posedge clk); #1; end
          dp_busy = 1'b0;
        end
      end
    end
  end

  // Job-level model, compared against the DUT on every falling edge.
  pair_t         pend_q[$];
  pair_t         cur;
  logic [DW-1:0] got_res[$];
  bit            job_active = 0, res_seen = 0, hs_pend = 0;
  int            starts = 0, timeouts = 0, cyc = 0;
  int            start_cyc = 0, res_cyc = 0, to_lat = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pend_q.delete();
      job_active = 0;
      res_seen   = 0;
      hs_pend    = 0;
    end else begin
      if (hs_pend) begin
        check_b("res_drop", res_valid, 1'b0);
        hs_pend    = 0;
        job_active = 0;
      end
      if (start) begin
        starts++;
        start_cyc = cyc;
        check_b("start_idle", job_active, 1'b0);
        check_b("start_busy", busy, 1'b0);
        check_b("start_job_avail", pend_q.size() != 0, 1'b1);
        if (pend_q.size() != 0) cur = pend_q[0];
        check_d("start_ar", ar_data, cur.a);
        check_d("start_br", br_data, cur.b);
        job_active = 1;
        res_seen   = 0;
      end else if (job_active) begin
        check_d("ar_hold", ar_data, cur.a);
        check_d("br_hold", br_data, cur.b);
      end
      if (res_valid) begin
        check_b("res_job", job_active, 1'b1);
        check_d("res_data", res_data, dp_fn(cur));
        if (!res_seen) begin
          res_seen = 1;
          res_cyc  = cyc;
          if (pend_q.size() != 0) void'(pend_q.pop_front());
        end
        if (res_ready) begin
          hs_pend = 1;
          got_res.push_back(res_data);
        end
      end
      if (timeout_err) begin
        timeouts++;
        to_lat = cyc - start_cyc;
        check_b("to_job", job_active, 1'b1);
        if (pend_q.size() != 0) void'(pend_q.pop_front());
        job_active = 0;
      end
      check_b("op_ready", op_ready, pend_q.size() != DEPTH);
      if (op_valid && op_ready) pend_q.push_back('{op_a, op_b});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    bit acc = 0;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      acc = op_ready;
      tick(1);
    end
    op_valid = 1'b0;
    check_b("push_accept", acc, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((pend_q.size() != 0 || job_active) && n < 500) begin
      tick(1);
      n++;
    end
    check_b(name, n < 500, 1'b1);
  endtask

  logic [DW-1:0] exp_b2b  [4] = '{-16'sd20, 16'sd10, -16'sd40, -16'sd60};
  logic [DW-1:0] exp_full [5] = '{16'sd109, 16'sd208, 16'sd307, 16'sd406, -16'sd495};
  int s0, s1, g0, t0;

  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b1;
    stall     = 1'b0;
    tick(3);
    check_b("rst_start", start, 1'b0);
    check_b("rst_res_valid", res_valid, 1'b0);
    check_b("rst_timeout", timeout_err, 1'b0);
    check_d("rst_ar", ar_data, '0);
    check_d("rst_br", br_data, '0);
    check_d("rst_res", res_data, '0);
    reset = 1'b0;
    tick(1);
    check_b("op_ready_after_reset", op_ready, 1'b1);

    // Single job.
    s0 = starts; g0 = got_res.size();
    push(16'sd50, 16'sd20);
    tick(1);
    check_b("issue_latency", start, 1'b1);
    drain("single_drain");
    check_i("single_starts", starts - s0, 1);
    check_i("single_latency", res_cyc - start_cyc, 8);
    check_d("single_res", got_res[g0], 16'sd40);

    // Back-to-back jobs.
    s0 = starts; g0 = got_res.size();
    push(16'sd20, 16'sd50);
    push(16'sd50, 16'sd50);
    push(16'sd0, 16'sd50);
    push(-16'sd20, 16'sd50);
    drain("b2b_drain");
    check_i("b2b_starts", starts - s0, 4);
    check_i("b2b_count", got_res.size() - g0, 4);
    for (int i = 0; i < 4; i++) check_d("b2b_res", got_res[g0 + i], exp_b2b[i]);

    // Full FIFO with the datapath stalled.
    stall = 1'b1;
    g0 = got_res.size();
    push(16'sd100, 16'sd1);
    push(16'sd200, 16'sd2);
    push(16'sd300, 16'sd3);
    push(16'sd400, 16'sd4);
    check_b("full_ready", op_ready, 1'b0);
    fork
      push(-16'sd500, 16'sd5);
      begin
        tick(5);
        check_b("full_hold", op_ready, 1'b0);
        stall = 1'b0;
      end
    join
    drain("full_drain");
    check_i("full_count", got_res.size() - g0, 5);
    for (int i = 0; i < 5; i++) check_d("full_res", got_res[g0 + i], exp_full[i]);

    // Timeout: the datapath ignores the first job.
    dp_skip = 1;
    s0 = starts; g0 = got_res.size(); t0 = timeouts;
    push(16'sd7, 16'sd7);
    push(16'sd8, 16'sd1);
    drain("to_drain");
    check_i("to_count", timeouts - t0, 1);
    check_i("to_latency", to_lat, TIMEOUT + 1);
    check_i("to_starts", starts - s0, 2);
    check_i("to_results", got_res.size() - g0, 1);
    check_d("to_next_res", got_res[g0], 16'sd17);

    // Result backpressure.
    res_ready = 1'b0;
    g0 = got_res.size();
    push(16'sd30, -16'sd5);
    push(16'sd31, 16'sd2);
    for (int n = 0; n < 100 && !res_valid; n++) tick(1);
    check_b("bp_valid", res_valid, 1'b1);
    s1 = starts;
    tick(10);
    check_b("bp_valid_hold", res_valid, 1'b1);
    check_d("bp_data_hold", res_data, 16'sd45);
    check_i("bp_nostart", starts - s1, 0);
    res_ready = 1'b1;
    drain("bp_drain");
    check_i("bp_count", got_res.size() - g0, 2);
    check_d("bp_res0", got_res[g0], 16'sd45);
    check_d("bp_res1", got_res[g0 + 1], 16'sd39);

`ifdef ISSUER_STATS_EN
    check_i("stats_done", int'(jobs_done), 13);
    check_i("stats_aborted", int'(jobs_aborted), 1);
`endif

    // Reset while in WAIT_DONE.
    push(16'sd60, 16'sd10);
    push(16'sd70, 16'sd1);
    for (int n = 0; n < 50 && !busy; n++) tick(1);
    check_b("rst_busy_seen", busy, 1'b1);
    tick(2);
    reset = 1'b1;
    #1;
    check_b("mid_rst_start", start, 1'b0);
    check_b("mid_rst_res_valid", res_valid, 1'b0);
    check_b("mid_rst_timeout", timeout_err, 1'b0);
    check_d("mid_rst_ar", ar_data, '0);
    check_d("mid_rst_br", br_data, '0);
    check_d("mid_rst_res", res_data, '0);
`ifdef ISSUER_STATS_EN
    check_i("mid_rst_done", int'(jobs_done), 0);
    check_i("mid_rst_aborted", int'(jobs_aborted), 0);
`endif
    tick(2);
    reset = 1'b0;
    for (int n = 0; n < 20 && busy; n++) tick(1);
    s0 = starts;
    tick(10);
    check_b("post_rst_ready", op_ready, 1'b1);
    check_i("post_rst_nostart", starts - s0, 0);

    // Normal resumption after reset.
    g0 = got_res.size();
    push(16'sd5, -16'sd5);
    drain("resume_drain");
    check_i("resume_count", got_res.size() - g0, 1);
    check_d("resume_res", got_res[g0], 16'sd20);
`ifdef ISSUER_STATS_EN
    check_i("resume_done", int'(jobs_done), 1);
    check_i("resume_aborted", int'(jobs_aborted), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
